// File: rtl/rv32i_wb_lsu_master.sv
// ---------------------------------------------------------------------------
// rv32i_wb_pkg
//   Wishbone B4 pipelined bus request/response bundles shared by the LSU
//   master and the bus fabric.
// ---------------------------------------------------------------------------
package rv32i_wb_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdata;
  } wb_master_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;
  } wb_slave_rsp_t;

  function automatic wb_master_req_t wb_master_req_default();
    return '0;
  endfunction

endpackage

// ---------------------------------------------------------------------------
// rv32i_wb_lsu_master
//   Wishbone B4 pipelined master for the load/store unit. Takes one
//   byte/half/word access over a valid/ready handshake, runs a single bus
//   cycle (one outstanding transaction) and returns aligned, extended load
//   data or an error. Misaligned and illegal-size accesses never reach the bus.
//
// Ports
//   clk_i, rst_i     clock; asynchronous active-high reset
//   req_valid_i      request valid       req_ready_o  high while IDLE
//   req_we_i         1 = store           req_addr_i   byte address
//   req_size_i       00 B, 01 H, 10 W, 11 illegal
//   req_unsigned_i   zero-extend loads   req_wdata_i  store data, right-justified
//   rsp_valid_o      one-cycle response  rsp_rdata_o  load result (0 on store/error)
//   rsp_err_o        bus error, misalignment or timeout
//   wb_req_o         registered Wishbone request bundle
//   wb_rsp_i         Wishbone slave response bundle
//
// Parameter
//   TIMEOUT_CYCLES   bus cycles (REQ + WAIT) before forced abort; 0 disables
// ---------------------------------------------------------------------------
module rv32i_wb_lsu_master
  import rv32i_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_we_i,
  input  logic [31:0]    req_addr_i,
  input  logic [1:0]     req_size_i,
  input  logic           req_unsigned_i,
  input  logic [31:0]    req_wdata_i,
  output logic           rsp_valid_o,
  output logic [31:0]    rsp_rdata_o,
  output logic           rsp_err_o,
  output wb_master_req_t wb_req_o,
  input  wb_slave_rsp_t  wb_rsp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  wb_master_req_t wb_req_q, wb_req_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]     off_q, off_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;

  logic           misaligned;
  logic           done;
  logic           abort;
  logic [31:0]    lane;
  logic [31:0]    load_data;

  assign req_ready_o = (state_q == IDLE);
  assign wb_req_o    = wb_req_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = (req_addr_i[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per access size.
  always_comb begin
    lane      = wb_rsp_i.rdata >> {off_q, 3'b000};
    load_data = lane;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    // NOTE: every value written here gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d     = state_q;
    wb_req_d    = wb_req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cnt_inc     = cnt_q + CW'(1);
    done        = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          off_d  = req_addr_i[1:0];
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          cnt_d  = '0;
          if (misaligned) begin
            // Rejected locally: error response next cycle, bus untouched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d        = REQ;
            wb_req_d.cyc   = 1'b1;
            wb_req_d.stb   = 1'b1;
            wb_req_d.we    = req_we_i;
            wb_req_d.adr   = {req_addr_i[31:2], 2'b00};
            case (req_size_i)
              2'b00: begin
                wb_req_d.sel   = 4'b0001 << req_addr_i[1:0];
                wb_req_d.wdata = {4{req_wdata_i[7:0]}};
              end
              2'b01: begin
                wb_req_d.sel   = 4'b0011 << req_addr_i[1:0];
                wb_req_d.wdata = {2{req_wdata_i[15:0]}};
              end
              default: begin
                wb_req_d.sel   = 4'b1111;
                wb_req_d.wdata = req_wdata_i;
              end
            endcase
          end
        end
      end

      REQ: begin
        cnt_d = cnt_inc;
        // A response is only meaningful once the slave has taken the strobe.
        if (!wb_rsp_i.stall) begin
          if (wb_rsp_i.ack || wb_rsp_i.err) begin
            done = 1'b1;
          end else begin
            state_d      = WAIT;
            wb_req_d.stb = 1'b0;
          end
        end
        if (!done && (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO)) abort = 1'b1;
      end

      WAIT: begin
        cnt_d = cnt_inc;
        if (wb_rsp_i.ack || wb_rsp_i.err) done = 1'b1;
        if (!done && (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO)) abort = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d     = IDLE;
      wb_req_d    = wb_master_req_default();
      rsp_valid_d = 1'b1;
      rsp_err_d   = wb_rsp_i.err;   // err wins over a simultaneous ack
      rsp_rdata_d = (wb_rsp_i.err || wb_req_q.we) ? 32'h0 : load_data;
    end else if (abort) begin
      state_d     = IDLE;
      wb_req_d    = wb_master_req_default();
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of all others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the datapath latches are reset too; the block is small and a
      // known post-reset value keeps the outputs free of X.
      state_q     <= IDLE;
      wb_req_q    <= wb_master_req_default();
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_req_q    <= wb_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

endmodule

// File: tb/tb_rv32i_wb_lsu_master.sv
// ---------------------------------------------------------------------------
// tb_rv32i_wb_lsu_master
//   Self-checking bench for rv32i_wb_lsu_master. Transactions push their
//   expected response into a scoreboard queue; a monitor pops and compares on
//   every rsp_valid. Bus-side fields are checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_rv32i_wb_lsu_master;
  import rv32i_wb_pkg::*;

  localparam int unsigned TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [31:0]    req_addr;
  logic [1:0]     req_size;
  logic           req_unsigned;
  logic [31:0]    req_wdata;
  logic           rsp_valid;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  wb_master_req_t wb_req;
  wb_slave_rsp_t  wb_rsp;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  rv32i_wb_lsu_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .wb_req_o       (wb_req),
    .wb_rsp_i       (wb_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    base = (size == 2'b00) ? 4'b0001 : (size == 2'b01) ? 4'b0011 : 4'b1111;
    return base << off;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'b00) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (size == 2'b01) return {w[15:0], w[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] d);
    logic [31:0] s;
    s = d >> (8 * off);
    if (size == 2'b00) return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (size == 2'b01) return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return s;
  endfunction

  // ---------------- response monitor ----------------
  always @(posedge clk) begin : mon
    logic [32:0] e;
    #1;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  // ---------------- transaction driver ----------------
  // Called mid-cycle (#1 after a rising edge). stalls = cycles stall is held
  // in REQ; ack_dly = 0 acks with the accepted strobe, n > 0 acks n cycles later.
  task automatic run_txn(input string tag, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int stalls, input int ack_dly,
                         input bit serr, input logic [31:0] exp_rdata);
    bit mis;
    bit eerr;
    mis  = is_misaligned(size, addr);
    eerr = mis || serr;
    check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    exp_q.push_back({eerr, eerr ? 32'h0 : exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;

    if (mis) begin
      check({tag, "_cyc"}, {31'h0, wb_req.cyc}, 32'd0);
      check({tag, "_rspv"}, {31'h0, rsp_valid}, 32'd1);
      return;
    end

    for (int k = 0; k <= stalls; k++) begin
      wb_rsp.stall = (k < stalls);
      check({tag, "_cyc"}, {31'h0, wb_req.cyc}, 32'd1);
      check({tag, "_stb"}, {31'h0, wb_req.stb}, 32'd1);
      check({tag, "_we"}, {31'h0, wb_req.we}, {31'h0, we});
      check({tag, "_adr"}, wb_req.adr, {addr[31:2], 2'b00});
      check({tag, "_sel"}, {28'h0, wb_req.sel}, {28'h0, model_sel(size, addr[1:0])});
      check({tag, "_wdata"}, wb_req.wdata, model_wdata(size, wdata));
      if (k == stalls && ack_dly == 0) begin
        wb_rsp.ack   = ~serr;
        wb_rsp.err   = serr;
        wb_rsp.rdata = rdata;
      end
      @(posedge clk); #1;
    end

    if (ack_dly > 0) begin
      for (int k = 1; k < ack_dly; k++) begin
        check({tag, "_wait_stb"}, {31'h0, wb_req.stb}, 32'd0);
        @(posedge clk); #1;
      end
      check({tag, "_wait_cyc"}, {31'h0, wb_req.cyc}, 32'd1);
      check({tag, "_wait_stb"}, {31'h0, wb_req.stb}, 32'd0);
      wb_rsp.ack   = ~serr;
      wb_rsp.err   = serr;
      wb_rsp.rdata = rdata;
      @(posedge clk); #1;
    end

    wb_rsp.ack = 1'b0;
    wb_rsp.err = 1'b0;
    check({tag, "_done_cyc"}, {31'h0, wb_req.cyc}, 32'd0);
    check({tag, "_rspv"}, {31'h0, rsp_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rsp_one_cycle"}, {31'h0, rsp_valid}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    wb_rsp       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", {31'h0, wb_req.cyc}, 32'd0);
    check("rst_stb", {31'h0, wb_req.stb}, 32'd0);
    check("rst_adr", wb_req.adr, 32'h0);
    check("rst_rspv", {31'h0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: LW, ack one cycle after the strobe
    run_txn("lw100", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 32'hDEADBEEF);
    drain("lw100");

    // 2: SB with three stall cycles
    run_txn("sb203", 1'b1, 32'h203, 2'b00, 1'b0, 32'h5A, 32'hFFFFFFFF, 3, 1, 1'b0, 32'h0);
    drain("sb203");

    // 3: sub-word load extension
    run_txn("lb202",  1'b0, 32'h202, 2'b00, 1'b0, 32'h0, 32'h00800000, 0, 1, 1'b0, 32'hFFFFFF80);
    run_txn("lbu202", 1'b0, 32'h202, 2'b00, 1'b1, 32'h0, 32'h00800000, 0, 1, 1'b0, 32'h00000080);
    run_txn("lh202",  1'b0, 32'h202, 2'b01, 1'b0, 32'h0, 32'h80010000, 0, 1, 1'b0, 32'hFFFF8001);
    run_txn("lhu202", 1'b0, 32'h202, 2'b01, 1'b1, 32'h0, 32'h80010000, 0, 1, 1'b0, 32'h00008001);
    run_txn("lb303",  1'b0, 32'h303, 2'b00, 1'b0, 32'h0, 32'h7F123456, 0, 1, 1'b0,
            model_load(2'b00, 1'b0, 2'b11, 32'h7F123456));
    run_txn("sh102",  1'b1, 32'h102, 2'b01, 1'b0, 32'hABCD1234, 32'h0, 1, 2, 1'b0, 32'h0);
    drain("ext");

    // Zero-wait back-to-back: next request issued in the rsp_valid cycle
    run_txn("b2b_a", 1'b0, 32'h500, 2'b10, 1'b0, 32'h0, 32'h11223344, 0, 0, 1'b0, 32'h11223344);
    run_txn("b2b_b", 1'b0, 32'h504, 2'b10, 1'b0, 32'h0, 32'h55667788, 0, 0, 1'b0, 32'h55667788);
    drain("b2b");

    // 4: misalignment, illegal size and slave error
    run_txn("lw102", 1'b0, 32'h102, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn("lh101", 1'b0, 32'h101, 2'b01, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn("sz11",  1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
    run_txn("lwerr", 1'b0, 32'h104, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1, 1'b1, 32'h0);
    drain("err");

    // 5: timeout with a silent slave, then a late ack
    check("tmo_ready", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h600; req_size = 2'b10; req_unsigned = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && wb_req.cyc === 1'b1; k++) begin
      n++;
      @(posedge clk); #1;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_rspv", {31'h0, rsp_valid}, 32'd1);
    wb_rsp.ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("tmo_late_rspv", {31'h0, rsp_valid}, 32'd0);
      check("tmo_late_cyc", {31'h0, wb_req.cyc}, 32'd0);
    end
    wb_rsp.ack = 1'b0;
    drain("tmo");

    // 6: reset while waiting for the slave
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h700; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_cyc", {31'h0, wb_req.cyc}, 32'd1);
    check("rstw_stb", {31'h0, wb_req.stb}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_async_cyc", {31'h0, wb_req.cyc}, 32'd0);
    check("rstw_async_stb", {31'h0, wb_req.stb}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_ready", {31'h0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rstw_no_rsp", {31'h0, rsp_valid}, 32'd0);
    end
    run_txn("lw_after_rst", 1'b0, 32'h704, 2'b10, 1'b0, 32'h0, 32'h0BADC0DE, 0, 1, 1'b0, 32'h0BADC0DE);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
